// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the 8-bit memory-mapped I/O bus: default widths,
// peripheral addresses, arbiter state encoding and small helpers.
package io_bus_pkg;

    // Default bus geometry.
    localparam int IO_AW = 8;
    localparam int IO_DW = 8;

    // Fixed peripheral addresses decoded by the slave side.
    localparam logic [IO_AW-1:0] LED_ADDR = 8'h80;

    // Arbiter sequencing: wait for a request, drive the one-cycle slave
    // strobe, then return the ack (and read data) to the owning master.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Kind of transaction captured at grant time.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // One-hot select for a two-master index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bundle of the two master request/response links and the single slave link
// of the I/O bus. Index 0 of every master vector is the CPU, index 1 the
// debug/loader port.
interface io_bus_arbiter_if #(
    parameter int AW = io_bus_pkg::IO_AW,
    parameter int DW = io_bus_pkg::IO_DW
);

    // Master side: level requests held until ack, registered responses.
    logic [1:0]         m_write;
    logic [1:0]         m_read;
    logic [1:0][AW-1:0] m_addr;
    logic [1:0][DW-1:0] m_dout;
    logic [1:0][DW-1:0] m_din;
    logic [1:0]         m_ack;

    // Slave side: one-cycle strobes, read data returned one cycle later.
    logic               s_write;
    logic               s_read;
    logic [AW-1:0]      s_addr;
    logic [DW-1:0]      s_dout;
    logic [DW-1:0]      s_din;

    // The arbiter sits between the masters and the slave.
    modport arb (
        input  m_write, m_read, m_addr, m_dout, s_din,
        output m_din, m_ack, s_write, s_read, s_addr, s_dout
    );

    // What the requesting masters see.
    modport master (
        output m_write, m_read, m_addr, m_dout,
        input  m_din, m_ack
    );

    // What the addressed peripheral sees.
    modport slave (
        input  s_write, s_read, s_addr, s_dout,
        output s_din
    );

endinterface

// File: rtl/io_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick. A master is eligible when it requests and is not
// masked; on contention the master that did not own the last transaction
// wins, so neither side can be starved.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_winner
);

    logic [1:0] w_elig;

    assign w_elig  = i_req & ~i_mask;
    assign o_valid = |w_elig;

    // Sole eligible master wins outright; with two, alternate away from i_last.
    always_comb begin
        o_winner = i_last;
        case (w_elig)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = ~i_last;
            default: o_winner = i_last;
        endcase
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master, one-slave arbiter for the 8-bit I/O bus. Exactly one
// transaction is in flight: grant in IDLE (or RESP), one-cycle slave strobe
// in ISSUE, ack pulse plus read data in RESP. RESP re-arbitrates with the
// just-acked master masked, so alternating masters get a strobe every 2 cycles.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int AW = IO_AW,
    parameter int DW = IO_DW
) (
    input  logic           clk,
    input  logic           rst,
    io_bus_arbiter_if.arb  bus,
    output logic           gnt,
    output logic           busy
);

    genvar gi;

    // Sequencer and captured-transaction registers.
    state_t             r_state;
    state_t             w_state_next;
    logic               r_gnt;
    logic               w_gnt_next;
    op_t                r_op;
    op_t                w_op_next;
    logic               r_busy;
    logic               w_busy_next;

    // Registered slave-side outputs.
    logic               r_s_write;
    logic               w_s_write_next;
    logic               r_s_read;
    logic               w_s_read_next;
    logic [AW-1:0]      r_s_addr;
    logic [AW-1:0]      w_s_addr_next;
    logic [DW-1:0]      r_s_dout;
    logic [DW-1:0]      w_s_dout_next;

    // Registered master-side responses.
    logic [1:0]         r_ack;
    logic [1:0]         w_ack_next;
    logic [1:0][DW-1:0] r_din;
    logic [1:0][DW-1:0] w_din_next;

    // Request decode and arbitration.
    logic [1:0]         w_req;
    logic [1:0]         w_is_write;
    logic [1:0]         w_mask;
    logic               w_arb_valid;
    logic               w_arb_winner;
    logic               w_take;

    // Write wins when a master raises write and read together.
    for (gi = 0; gi < 2; gi++) begin : g_req
        assign w_req[gi]      = bus.m_write[gi] | bus.m_read[gi];
        assign w_is_write[gi] = bus.m_write[gi];
    end

    // In RESP the acked master still holds its request for this cycle, so it
    // is excluded; a waiting peer therefore always goes next.
    assign w_mask = (r_state == RESP) ? onehot2(r_gnt) : 2'b00;

    rr_arb2 u_rr_arb2 (
        .i_req    (w_req),
        .i_mask   (w_mask),
        .i_last   (r_gnt),
        .o_valid  (w_arb_valid),
        .o_winner (w_arb_winner)
    );

    // Next-state and next-output decode; everything defaults to hold/idle.
    always_comb begin
        w_state_next   = r_state;
        w_gnt_next     = r_gnt;
        w_op_next      = r_op;
        w_s_write_next = 1'b0;
        w_s_read_next  = 1'b0;
        w_s_addr_next  = r_s_addr;
        w_s_dout_next  = r_s_dout;
        w_ack_next     = 2'b00;
        w_din_next     = r_din;
        w_take         = 1'b0;

        case (r_state)
            IDLE: begin
                w_take = w_arb_valid;
            end
            ISSUE: begin
                w_state_next = RESP;
                w_ack_next   = onehot2(r_gnt);
            end
            RESP: begin
                // Keep the returned read data so the master can still see it
                // after the ack cycle; a write leaves din untouched.
                if (r_op == OP_READ) begin
                    w_din_next[r_gnt] = bus.s_din;
                end
                w_state_next = IDLE;
                w_take       = w_arb_valid;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A grant captures the winner's op, address and data once; later
        // changes on its inputs do not touch the in-flight transaction.
        if (w_take) begin
            w_state_next   = ISSUE;
            w_gnt_next     = w_arb_winner;
            w_op_next      = w_is_write[w_arb_winner] ? OP_WRITE : OP_READ;
            w_s_write_next = w_is_write[w_arb_winner];
            w_s_read_next  = ~w_is_write[w_arb_winner];
            w_s_addr_next  = bus.m_addr[w_arb_winner];
            w_s_dout_next  = bus.m_dout[w_arb_winner];
        end

        w_busy_next = (w_state_next != IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output and captured-transaction registers; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gnt     <= 1'b1;
            r_op      <= OP_READ;
            r_busy    <= 1'b0;
            r_s_write <= 1'b0;
            r_s_read  <= 1'b0;
            r_s_addr  <= '0;
            r_s_dout  <= '0;
            r_ack     <= 2'b00;
            r_din     <= '0;
        end else begin
            r_gnt     <= w_gnt_next;
            r_op      <= w_op_next;
            r_busy    <= w_busy_next;
            r_s_write <= w_s_write_next;
            r_s_read  <= w_s_read_next;
            r_s_addr  <= w_s_addr_next;
            r_s_dout  <= w_s_dout_next;
            r_ack     <= w_ack_next;
            r_din     <= w_din_next;
        end
    end

    assign bus.s_write = r_s_write;
    assign bus.s_read  = r_s_read;
    assign bus.s_addr  = r_s_addr;
    assign bus.s_dout  = r_s_dout;
    assign gnt         = r_gnt;
    assign busy        = r_busy;

    // The slave registers its read data, so it only exists during RESP; it is
    // forwarded to the owner in the ack cycle and held in r_din afterwards.
    for (gi = 0; gi < 2; gi++) begin : g_master
        assign bus.m_ack[gi] = r_ack[gi];
        assign bus.m_din[gi] = (r_state == RESP && r_op == OP_READ && r_gnt == 1'(gi))
                               ? bus.s_din : r_din[gi];
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed scenarios with literal expectations,
// then randomized masters checked every cycle against a transaction-level
// model of the arbitration rules.
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic gnt;
    logic busy;

    io_bus_arbiter_if #(.AW(8), .DW(8)) bus ();

    io_bus_arbiter #(.AW(8), .DW(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .gnt  (gnt),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Slave contents: LED register reads back 3, anything else a fixed pattern.
    function automatic logic [7:0] slave_fn(input logic [7:0] a);
        return (a == LED_ADDR) ? 8'h03 : (a ^ 8'hA5);
    endfunction

    // ---------------- transaction-level reference model ----------------
    bit         armed = 0;
    int         cyc = 0;
    logic       e_sw, e_sr, e_gnt, e_busy;
    logic [7:0] e_addr, e_dout;
    logic [1:0] e_ack;
    logic [7:0] e_din  [2];
    logic [7:0] held_din [2];
    bit         infl = 0;
    int         t_m, t_issue, masked, w;
    bit         t_wr, r0, r1;
    logic [7:0] t_addr, t_data;
    logic       prev_s_read = 1'b0;
    logic [7:0] prev_s_addr = 8'h00;
    logic [1:0] ack_seen = 2'b00;

    always @(negedge clk) begin
        if (armed) begin
            chk("s_write", 32'(bus.s_write), 32'(e_sw));
            chk("s_read",  32'(bus.s_read),  32'(e_sr));
            chk("m_ack",   32'(bus.m_ack),   32'(e_ack));
            chk("gnt",     32'(gnt),         32'(e_gnt));
            chk("busy",    32'(busy),        32'(e_busy));
            if (e_sw || e_sr) begin
                chk("s_addr", 32'(bus.s_addr), 32'(e_addr));
                chk("s_dout", 32'(bus.s_dout), 32'(e_dout));
            end
            for (int m = 0; m < 2; m++) begin
                if (e_ack[m]) begin
                    chk("m_din", 32'(bus.m_din[m]), 32'(e_din[m]));
                    $display("txn m%0d %s addr=%02h data=%02h cyc=%0d", m,
                             t_wr ? "WR" : "RD", t_addr, t_wr ? t_data : e_din[m], cyc);
                end
            end
        end
        prev_s_read = bus.s_read;
        prev_s_addr = bus.s_addr;
        ack_seen    = bus.m_ack;

        // Expected outputs for the next cycle from this cycle's inputs.
        if (!rst) begin
            e_sw = 0; e_sr = 0; e_addr = 8'h00; e_dout = 8'h00;
            e_ack = 2'b00; e_gnt = 1'b1; e_busy = 1'b0;
            held_din[0] = 8'h00; held_din[1] = 8'h00;
            infl = 0;
            armed = 1;
        end else begin
            e_sw = 0; e_sr = 0; e_ack = 2'b00; e_busy = 0;
            if (infl && cyc == t_issue) begin
                // Strobe cycle now; the ack follows next cycle.
                e_ack[t_m] = 1'b1;
                e_busy = 1'b1;
                e_din[t_m] = t_wr ? held_din[t_m] : slave_fn(t_addr);
                held_din[t_m] = e_din[t_m];
            end else begin
                masked = (infl && cyc == t_issue + 1) ? t_m : -1;
                infl = 0;
                r0 = (bus.m_write[0] | bus.m_read[0]) && (masked != 0);
                r1 = (bus.m_write[1] | bus.m_read[1]) && (masked != 1);
                if (r0 || r1) begin
                    w = (r0 && r1) ? (e_gnt ? 0 : 1) : (r1 ? 1 : 0);
                    infl = 1; t_m = w; t_issue = cyc + 1;
                    t_wr = bus.m_write[w];
                    t_addr = bus.m_addr[w]; t_data = bus.m_dout[w];
                    e_sw = t_wr; e_sr = !t_wr;
                    e_addr = t_addr; e_dout = t_data;
                    e_gnt = w[0]; e_busy = 1'b1;
                end
            end
        end
        cyc++;
    end

    // Advance one cycle; the registered slave answers the previous s_read.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.s_din = prev_s_read ? slave_fn(prev_s_addr) : 8'($urandom);
    endtask

    bit req_on [2];
    int op;

    initial begin
        rst = 1'b0;
        bus.m_write = 2'b01; bus.m_read = 2'b00;
        bus.m_addr = '0; bus.m_dout = '0; bus.s_din = 8'h00;

        // Reset held for two cycles with a pending m0 write.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst s_write", 32'(bus.s_write), 32'h0);
        chk("rst s_read",  32'(bus.s_read),  32'h0);
        chk("rst m_ack",   32'(bus.m_ack),   32'h0);
        chk("rst gnt",     32'(gnt),         32'h1);
        chk("rst busy",    32'(busy),        32'h0);
        next_cycle(); rst = 1'b1; bus.m_write = 2'b00;
        next_cycle();

        // Single write from m0.
        next_cycle(); bus.m_write[0] = 1'b1; bus.m_addr[0] = 8'h80; bus.m_dout[0] = 8'h05;
        @(negedge clk); chk("wr t s_write", 32'(bus.s_write), 32'h0);
        next_cycle(); @(negedge clk);
        chk("wr t1 s_write", 32'(bus.s_write), 32'h1);
        chk("wr t1 s_addr",  32'(bus.s_addr),  32'h80);
        chk("wr t1 s_dout",  32'(bus.s_dout),  32'h05);
        next_cycle(); @(negedge clk);
        chk("wr t2 m_ack",   32'(bus.m_ack),   32'h1);
        chk("wr t2 s_write", 32'(bus.s_write), 32'h0);
        next_cycle(); bus.m_write[0] = 1'b0; @(negedge clk);
        chk("wr t3 m_ack", 32'(bus.m_ack), 32'h0);
        chk("wr t3 busy",  32'(busy),      32'h0);

        // Single read from m1 of the LED register.
        next_cycle(); bus.m_read[1] = 1'b1; bus.m_addr[1] = 8'h80;
        next_cycle(); @(negedge clk);
        chk("rd t1 s_read", 32'(bus.s_read), 32'h1);
        chk("rd t1 s_addr", 32'(bus.s_addr), 32'h80);
        next_cycle(); @(negedge clk);
        chk("rd t2 m_ack", 32'(bus.m_ack),    32'h2);
        chk("rd t2 m1_din", 32'(bus.m_din[1]), 32'h03);
        next_cycle(); bus.m_read[1] = 1'b0;

        // Contention straight out of reset: m0 first, then m1.
        next_cycle(); rst = 1'b0;
        next_cycle(); rst = 1'b1;
        bus.m_write = 2'b11;
        bus.m_addr[0] = 8'h10; bus.m_dout[0] = 8'h11;
        bus.m_addr[1] = 8'h20; bus.m_dout[1] = 8'h22;
        next_cycle(); @(negedge clk);
        chk("ct t1 s_addr", 32'(bus.s_addr), 32'h10);
        chk("ct t1 gnt",    32'(gnt),        32'h0);
        next_cycle(); @(negedge clk);
        chk("ct t2 m_ack", 32'(bus.m_ack), 32'h1);
        next_cycle(); bus.m_write[0] = 1'b0; @(negedge clk);
        chk("ct t3 s_write", 32'(bus.s_write), 32'h1);
        chk("ct t3 s_addr",  32'(bus.s_addr),  32'h20);
        chk("ct t3 gnt",     32'(gnt),         32'h1);
        next_cycle(); @(negedge clk);
        chk("ct t4 m_ack", 32'(bus.m_ack), 32'h2);
        next_cycle(); bus.m_write[1] = 1'b0;
        next_cycle();

        // Write and read raised together on m0 act as a write.
        next_cycle(); bus.m_write[0] = 1'b1; bus.m_read[0] = 1'b1;
        bus.m_addr[0] = 8'h42; bus.m_dout[0] = 8'h99;
        next_cycle(); @(negedge clk);
        chk("wr+rd s_write", 32'(bus.s_write), 32'h1);
        chk("wr+rd s_read",  32'(bus.s_read),  32'h0);
        next_cycle(); @(negedge clk);
        chk("wr+rd m_ack", 32'(bus.m_ack), 32'h1);
        next_cycle(); bus.m_write[0] = 1'b0; bus.m_read[0] = 1'b0;
        next_cycle();

        // Reset during the strobe cycle aborts; the held request then completes.
        next_cycle(); bus.m_write[0] = 1'b1; bus.m_addr[0] = 8'h80; bus.m_dout[0] = 8'h07;
        next_cycle(); rst = 1'b0; @(negedge clk);
        chk("ri t1 s_write", 32'(bus.s_write), 32'h1);
        next_cycle(); rst = 1'b1; @(negedge clk);
        chk("ri t2 m_ack", 32'(bus.m_ack), 32'h0);
        chk("ri t2 busy",  32'(busy),      32'h0);
        chk("ri t2 gnt",   32'(gnt),       32'h1);
        next_cycle(); @(negedge clk);
        chk("ri t3 s_write", 32'(bus.s_write), 32'h1);
        next_cycle(); @(negedge clk);
        chk("ri t4 m_ack", 32'(bus.m_ack), 32'h1);
        next_cycle(); bus.m_write[0] = 1'b0;
        next_cycle();

        // Randomized masters obeying the hold-until-ack protocol.
        req_on[0] = 0; req_on[1] = 0;
        for (int c = 0; c < 2000; c++) begin
            next_cycle();
            rst = ($urandom_range(0, 99) != 0);
            for (int m = 0; m < 2; m++) begin
                if (req_on[m] && !ack_seen[m]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.m_addr[m] = 8'($urandom);
                        bus.m_dout[m] = 8'($urandom);
                    end
                end else begin
                    req_on[m] = ($urandom_range(0, 2) != 0);
                    op = $urandom_range(0, 2);
                    bus.m_write[m] = req_on[m] && (op != 1);
                    bus.m_read[m]  = req_on[m] && (op != 0);
                    bus.m_addr[m]  = ($urandom_range(0, 3) == 0) ? LED_ADDR : 8'($urandom);
                    bus.m_dout[m]  = 8'($urandom);
                end
            end
        end
        next_cycle(); rst = 1'b1; bus.m_write = 2'b00; bus.m_read = 2'b00;
        repeat (4) next_cycle();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
